// File: rtl/alu_seq_if.sv
// Operand/result bundle for alu_seq: the pipeline drives start/control/operands,
// the ALU returns registered results plus busy/done status.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       control;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             ovf;
  logic             dbz;
  logic             busy;
  logic             done;

  modport master (
    output start, control, in1, in2,
    input  out, hi, zero, ovf, dbz, busy, done
  );

  modport slave (
    input  start, control, in1, in2,
    output out, hi, zero, ovf, dbz, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with iterative MULU/DIVU: 1 clock to done for simple ops, WIDTH+1 for mul/div.
// No queuing: start is honoured only in IDLE; busy stalls the issuing stage meanwhile.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int M  = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] opa, opb, acc;
  logic [WIDTH-1:0] out_q, hi_q;
  logic             zero_q, ovf_q, dbz_q;
  logic             is_div;
  logic [CW-1:0]    cnt;

  logic             is_mul_op, is_div_op, long_op;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic [SHW-1:0]   sh;

  logic [WIDTH:0]   madd, rsh, trial;
  logic [WIDTH-1:0] step_acc, step_b;
  logic             qbit;

  assign is_mul_op = (bus.control == 4'd12);
  assign is_div_op = (bus.control == 4'd13);
  assign long_op   = is_mul_op || (is_div_op && (bus.in2 != '0));

  always_comb begin
    sum     = bus.in1 + bus.in2;
    diff    = bus.in1 - bus.in2;
    sh      = bus.in2[SHW-1:0];
    alu_res = bus.in1;
    alu_ovf = 1'b0;
    case (bus.control)
      4'd0: begin
        alu_res = sum;
        alu_ovf = (bus.in1[M] == bus.in2[M]) && (sum[M] != bus.in1[M]);
      end
      4'd1: begin
        alu_res = diff;
        alu_ovf = (bus.in1[M] != bus.in2[M]) && (diff[M] != bus.in1[M]);
      end
      4'd2:  alu_res = bus.in1 & bus.in2;
      4'd3:  alu_res = bus.in1 | bus.in2;
      4'd4:  alu_res = bus.in1 << sh;
      4'd5:  alu_res = bus.in1 >> sh;
      4'd6:  alu_res = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
      4'd8:  alu_res = WIDTH'($signed(bus.in1) >>> sh);
      4'd9:  alu_res = bus.in1 ^ bus.in2;
      4'd10: alu_res = ~(bus.in1 | bus.in2);
      4'd13: alu_res = '1;
      default: alu_res = bus.in1;
    endcase
  end

  // Multiply keeps the product in {acc, opb}; divide shifts the dividend out of opb
  // into acc while quotient bits shift in from the bottom.
  always_comb begin
    madd     = {1'b0, acc} + (opb[0] ? {1'b0, opa} : '0);
    rsh      = {acc, opb[M]};
    trial    = rsh - {1'b0, opa};
    qbit     = ~trial[WIDTH];
    step_acc = madd[WIDTH:1];
    step_b   = {madd[0], opb[M:1]};
    if (is_div) begin
      step_acc = qbit ? trial[M:0] : rsh[M:0];
      step_b   = {opb[M-1:0], qbit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = long_op ? RUN : DONE;
      RUN:     if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
      out_q  <= '0;
      hi_q   <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
      dbz_q  <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      if (long_op) begin
        opa    <= is_mul_op ? bus.in1 : bus.in2;
        opb    <= is_mul_op ? bus.in2 : bus.in1;
        acc    <= '0;
        is_div <= is_div_op;
        cnt    <= CW'(WIDTH);
      end else begin
        // A DIVU reaching here has a zero divisor.
        out_q  <= alu_res;
        hi_q   <= is_div_op ? bus.in1 : '0;
        zero_q <= (alu_res == '0);
        ovf_q  <= alu_ovf;
        dbz_q  <= is_div_op;
      end
    end else if (state == RUN) begin
      acc <= step_acc;
      opb <= step_b;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        out_q  <= step_b;
        hi_q   <= step_acc;
        zero_q <= (step_b == '0);
        ovf_q  <= 1'b0;
        dbz_q  <= 1'b0;
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.hi   = hi_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
  assign bus.dbz  = dbz_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, random ops against an arithmetic model,
// and hand-written start-during-MULU and reset-during-DIVU sequences.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] last_out = '0;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a, b, o, h;
    logic        z, v, d;
    int          cyc;
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Reference results from plain integer arithmetic.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic [31:0] h,
                                output logic z, output logic v, output logic d, output int cyc);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o = a; h = '0; v = 1'b0; d = 1'b0; cyc = 1;
    case (c)
      4'd0: begin s = sa + sb; o = a + b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sa - sb; o = a - b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: o = a & b;
      4'd3: o = a | b;
      4'd4: o = a << b[4:0];
      4'd5: o = a >> b[4:0];
      4'd6: o = (a < b) ? 32'd1 : 32'd0;
      4'd7: o = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: o = 32'($signed(a) >>> b[4:0]);
      4'd9: o = a ^ b;
      4'd10: o = ~(a | b);
      4'd12: begin p = {32'd0, a} * {32'd0, b}; o = p[31:0]; h = p[63:32]; cyc = 33; end
      4'd13: begin
        if (b == 0) begin o = '1; h = a; d = 1'b1; end
        else begin o = a / b; h = a % b; cyc = 33; end
      end
      default: o = a;
    endcase
    z = (o == 0);
  endfunction

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    if (bus.busy) chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eo, input logic [31:0] eh,
                          input logic ez, input logic ev, input logic ed, input int ecyc);
    int cyc;
    wait_idle();
    bus.start = 1'b1; bus.control = c; bus.in1 = a; bus.in2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      chk({name, "_busy"}, 64'(bus.busy), 64'd1);
      if (bus.done) begin cyc = i; break; end
      chk({name, "_hold"}, 64'(bus.out), 64'(last_out));
      @(posedge clk); #1;
    end
    chk({name, "_cyc"}, 64'(cyc), 64'(ecyc));
    chk({name, "_out"}, 64'(bus.out), 64'(eo));
    chk({name, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({name, "_flags"}, {61'd0, bus.zero, bus.ovf, bus.dbz}, {61'd0, ez, ev, ed});
    last_out = eo;
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_out"}, 64'(bus.out), 64'd0);
    chk({name, "_hi"}, 64'(bus.hi), 64'd0);
    chk({name, "_flags"}, {59'd0, bus.zero, bus.ovf, bus.dbz, bus.busy, bus.done}, 64'b10000);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b, o, h;
    logic        z, v, d;
    int          cyc, ndone;
    logic [31:0] dout, dhi;

    bus.start = 1'b0; bus.control = '0; bus.in1 = '0; bus.in2 = '0;

    vecs.push_back('{4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd1,  32'd5,        32'd5,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd7,  32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd6,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd8,  32'h80000000, 32'd4,        32'hF8000000, 32'h0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{4'd13, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{4'd13, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd1,  32'h80000000, 32'h1,        32'h7FFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd4,  32'h1,        32'd35,       32'h8,        32'h0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd5,  32'h80000000, 32'd31,       32'h1,        32'h0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd7,  32'h1,        32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd2,  32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 32'h0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd3,  32'h12340000, 32'h00005678, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd9,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 32'h0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd10, 32'hFF00FF00, 32'h00FF00FF, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd11, 32'hDEADBEEF, 32'h5,        32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd15, 32'h0,        32'h5,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd12, 32'h10000,    32'h10000,    32'h0,        32'h1,        1'b1, 1'b0, 1'b0, 33});
    vecs.push_back('{4'd13, 32'd5,        32'd9,        32'h0,        32'd5,        1'b1, 1'b0, 1'b0, 33});

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_idle");

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].o,
               vecs[i].h, vecs[i].z, vecs[i].v, vecs[i].d, vecs[i].cyc);

    for (int i = 0; i < 150; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      model(c, a, b, o, h, z, v, d, cyc);
      check_op($sformatf("rnd%0d_op%0d", i, c), c, a, b, o, h, z, v, d, cyc);
    end

    // ADD pulsed while a MULU is in flight must be dropped.
    wait_idle();
    bus.start = 1'b1; bus.control = 4'd12; bus.in1 = 32'd3; bus.in2 = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.control = 4'd0; bus.in1 = 32'd1; bus.in2 = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0; dout = '0; dhi = '1;
    for (int i = 0; i < 45; i++) begin
      if (bus.done) begin ndone++; dout = bus.out; dhi = bus.hi; end
      @(posedge clk); #1;
    end
    chk("mid_mul_ndone", 64'(ndone), 64'd1);
    chk("mid_mul_out", 64'(dout), 64'd15);
    chk("mid_mul_hi", 64'(dhi), 64'd0);
    last_out = 32'd15;

    // Reset during RUN of a DIVU aborts it without a done.
    wait_idle();
    bus.start = 1'b1; bus.control = 4'd13; bus.in1 = 32'd1000; bus.in2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    last_out = '0;
    check_op("post_abort_add", 4'd0, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1);
    check_op("post_abort_div", 4'd13, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 1'b0, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
